// File: rtl/ysyx_ifu_icache_pkg.sv
// rtl/ysyx_ifu_icache_pkg.sv - shared state encoding and field-width helpers for the IFU icache
package ysyx_ifu_icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_AR     = 3'd2,
        S_RDATA  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam int DEF_SETS       = 16;
    localparam int DEF_LINE_WORDS = 4;

    // A single-word line still needs a 1-bit word select so the arrays index cleanly.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_OFF_W  = $clog2(DEF_LINE_WORDS) + 2;
    localparam int DEF_IDX_W  = $clog2(DEF_SETS);
    localparam int DEF_WORD_W = clog2_min1(DEF_LINE_WORDS);

endpackage

// File: rtl/ysyx_icache_way.sv
// rtl/ysyx_icache_way.sv - one way of the icache: data, tag and valid arrays with bulk invalidate
module ysyx_icache_way #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 4,
    parameter int WORD_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inval_all,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              data_we,
    input  logic              tag_we
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [DATA_W-1:0] data [SETS][LINE_WORDS];

    // Invalidate wins over install so a flush coinciding with the last beat drops the new line.
    always_ff @(posedge clk) begin
        if (!rst || inval_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tags[wr_index] <= wr_tag;
        end
        if (data_we) begin
            data[wr_index][wr_word] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_word];

endmodule

// File: rtl/ysyx_ifu_icache.sv
// rtl/ysyx_ifu_icache.sv - set-associative instruction cache with burst refill, kill and fence.i flush
module ysyx_ifu_icache
    import ysyx_ifu_icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_pc,
    output logic [DATA_W-1:0] resp_inst,
    input  logic              kill,
    input  logic              flush,
    output logic              bus_arvalid,
    input  logic              bus_arready,
    output logic [ADDR_W-1:0] bus_araddr,
    output logic [7:0]        bus_arlen,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rlast
);

    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WORD_W = clog2_min1(LINE_WORDS);

    state_t            state;
    logic [ADDR_W-1:0] pc_r;
    logic [WORD_W-1:0] beat_cnt;
    logic              vic_r;
    logic              kill_pend;
    logic              flush_pend;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;

    assign idx  = pc_r[OFF_W +: IDX_W];
    assign tag  = pc_r[ADDR_W-1 -: TAG_W];
    assign word = WORD_W'(pc_r >> 2) & WORD_W'(LINE_WORDS - 1);

    logic [WAYS-1:0]   way_valid;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [DATA_W-1:0] way_data [WAYS];

    logic beat_fire;
    logic flush_now;
    assign beat_fire = (state == S_RDATA) && bus_rvalid;
    assign flush_now = (flush || flush_pend) &&
                       (state == S_IDLE || state == S_RESP || (beat_fire && bus_rlast));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        ysyx_icache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W),
            .DATA_W(DATA_W), .IDX_W(IDX_W), .WORD_W(WORD_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .inval_all(flush_now),
            .rd_index (idx),
            .rd_word  (word),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w]),
            .wr_index (idx),
            .wr_word  (beat_cnt),
            .wr_data  (bus_rdata),
            .wr_tag   (tag),
            .data_we  (beat_fire && (vic_r == 1'(w))),
            .tag_we   (beat_fire && bus_rlast && (vic_r == 1'(w)))
        );
    end

    logic              hit;
    logic              hit_way;
    logic [DATA_W-1:0] hit_data;
    logic              victim;
    logic              lru_bit;

    always_comb begin
        hit      = 1'b0;
        hit_way  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && way_tag[w] == tag) begin
                hit      = 1'b1;
                hit_way  = 1'(w);
                hit_data = way_data[w];
            end
        end
    end

    // Lowest-numbered invalid way first, otherwise the LRU way.
    always_comb begin
        victim = lru_bit;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = 1'(w);
            end
        end
    end

    logic lru_upd;
    logic lru_way;
    assign lru_upd = (state == S_LOOKUP && !kill && hit) || (beat_fire && bus_rlast);
    assign lru_way = (state == S_LOOKUP) ? hit_way : vic_r;

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru;
        always_ff @(posedge clk) begin
            if (!rst) begin
                lru <= '0;
            end else if (lru_upd) begin
                lru[idx] <= ~lru_way;
            end
        end
        assign lru_bit = lru[idx];
    end else begin : g_nolru
        assign lru_bit = 1'b0;
    end

    assign resp_pc   = pc_r;
    assign bus_arlen = 8'(LINE_WORDS - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_inst   <= '0;
            bus_arvalid <= 1'b0;
            bus_araddr  <= '0;
            pc_r        <= '0;
            beat_cnt    <= '0;
            vic_r       <= 1'b0;
            kill_pend   <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            if (flush_now) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid && !kill) begin
                        pc_r      <= req_pc;
                        req_ready <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (kill) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else if (hit) begin
                        resp_inst  <= hit_data;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        vic_r       <= victim;
                        kill_pend   <= 1'b0;
                        bus_arvalid <= 1'b1;
                        bus_araddr  <= {pc_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state       <= S_AR;
                    end
                end
                S_AR: begin
                    if (kill) begin
                        kill_pend <= 1'b1;
                    end
                    if (bus_arready) begin
                        bus_arvalid <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (kill) begin
                        kill_pend <= 1'b1;
                    end
                    if (bus_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == word) begin
                            resp_inst <= bus_rdata;
                        end
                        if (bus_rlast) begin
                            if (kill || kill_pend) begin
                                req_ready <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                resp_valid <= 1'b1;
                                state      <= S_RESP;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (kill || resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_ifu_icache.sv
// tb/tb_ysyx_ifu_icache.sv - directed self-checking bench for the IFU icache
module tb_ysyx_ifu_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_pc;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_pc, resp_inst;
    logic        kill, flush;
    logic        bus_arvalid, bus_arready;
    logic [31:0] bus_araddr;
    logic [7:0]  bus_arlen;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_rlast;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_ifu_icache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_pc(resp_pc), .resp_inst(resp_inst),
        .kill(kill), .flush(flush),
        .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_araddr(bus_araddr), .bus_arlen(bus_arlen),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rlast(bus_rlast)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic serve_ar(input logic [31:0] addr);
        check("arvalid", 64'(bus_arvalid), 64'd1);
        check("araddr", 64'(bus_araddr), 64'(addr));
        check("arlen", 64'(bus_arlen), 64'd3);
        bus_arready = 1'b1;
        @(negedge clk);
        bus_arready = 1'b0;
        check("arvalid_drop", 64'(bus_arvalid), 64'd0);
    endtask

    // Beat k carries seed*(k+1); kill/flush are raised during the named beat (-1 = never).
    task automatic beats(input logic [31:0] seed, input int kill_k, input int flush_k);
        for (int k = 0; k < 4; k++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = seed * (k + 1);
            bus_rlast  = (k == 3);
            kill       = (k == kill_k);
            flush      = (k == flush_k);
            @(negedge clk);
        end
        bus_rvalid = 1'b0;
        bus_rlast  = 1'b0;
        kill       = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic take_resp(input logic [31:0] pc, input logic [31:0] inst);
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_pc", 64'(resp_pc), 64'(pc));
        check("resp_inst", 64'(resp_inst), 64'(inst));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_done", 64'(resp_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] inst);
        issue(pc);
        @(negedge clk);
        check("hit_no_ar", 64'(bus_arvalid), 64'd0);
        take_resp(pc, inst);
    endtask

    task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] seed, input logic [31:0] inst);
        issue(pc);
        @(negedge clk);
        serve_ar({pc[31:4], 4'h0});
        beats(seed, -1, -1);
        take_resp(pc, inst);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 0; req_pc = '0; resp_ready = 0; kill = 0; flush = 0;
        bus_arready = 0; bus_rvalid = 0; bus_rdata = '0; bus_rlast = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_arvalid", 64'(bus_arvalid), 64'd0);
        check("rst_araddr", 64'(bus_araddr), 64'd0);
        check("rst_arlen", 64'(bus_arlen), 64'd3);
        rst = 1'b1;
        @(negedge clk);

        // cold miss then hit in the same line
        fetch_miss(32'h8000_0004, 32'h11, 32'h22);
        fetch_hit(32'h8000_000C, 32'h44);

        // conflict: A way0, B way1, touch A, C evicts B, A still hits, B misses again
        fetch_miss(32'h8000_0100, 32'h1000, 32'h1000);
        fetch_hit(32'h8000_0008, 32'h33);
        fetch_miss(32'h8000_0200, 32'h2000, 32'h2000);
        fetch_hit(32'h8000_0000, 32'h11);
        fetch_miss(32'h8000_0104, 32'h1000, 32'h2000);

        // kill during beat 2: no response, line still installed
        issue(32'h8000_0308);
        @(negedge clk);
        serve_ar(32'h8000_0300);
        beats(32'h3000, 2, -1);
        check("kill_no_resp", 64'(resp_valid), 64'd0);
        check("kill_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("kill_no_resp2", 64'(resp_valid), 64'd0);
        fetch_hit(32'h8000_0308, 32'h9000);

        // flush in IDLE makes the same PC miss
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch_miss(32'h8000_0308, 32'h3000, 32'h9000);

        // flush during refill: response still delivered, line then invalid
        issue(32'h8000_0504);
        @(negedge clk);
        serve_ar(32'h8000_0500);
        beats(32'h500, -1, 1);
        take_resp(32'h8000_0504, 32'hA00);
        fetch_miss(32'h8000_0504, 32'h500, 32'hA00);

        // backpressure: response held stable for 5 cycles
        issue(32'h8000_0048);
        @(negedge clk);
        serve_ar(32'h8000_0040);
        beats(32'h40, -1, -1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_pc", 64'(resp_pc), 64'h8000_0048);
            check("bp_inst", 64'(resp_inst), 64'hC0);
            @(negedge clk);
        end
        take_resp(32'h8000_0048, 32'hC0);

        // kill with req_valid in IDLE ignores the request
        req_valid = 1'b1; req_pc = 32'h8000_0048; kill = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        check("killidle_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("killidle_no_resp", 64'(resp_valid), 64'd0);

        // kill in LOOKUP drops a would-be hit
        issue(32'h8000_0048);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("killlk_no_resp", 64'(resp_valid), 64'd0);
        check("killlk_ready", 64'(req_ready), 64'd1);

        // reset mid-refill, stray beat ignored, earlier lines gone
        issue(32'h8000_0080);
        @(negedge clk);
        serve_ar(32'h8000_0080);
        bus_rvalid = 1'b1; bus_rdata = 32'h77;
        @(negedge clk);
        bus_rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstmid_resp_valid", 64'(resp_valid), 64'd0);
        check("rstmid_req_ready", 64'(req_ready), 64'd1);
        check("rstmid_arvalid", 64'(bus_arvalid), 64'd0);
        bus_rvalid = 1'b1; bus_rlast = 1'b1; bus_rdata = 32'h99;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_rlast = 1'b0;
        check("stray_no_resp", 64'(resp_valid), 64'd0);
        check("stray_ready", 64'(req_ready), 64'd1);
        fetch_miss(32'h8000_0048, 32'h40, 32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
